// File: rtl/ifid_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: occupancy encodings
// and the register-field positions decoded from the held instruction.
package ifid_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

endpackage

// File: rtl/ifid_entry.sv
// One registered pc/inst/valid slot. Clear wins over load; a cleared slot
// holds pc 0 and the NOP encoding so idle outputs are well defined.
module ifid_entry #(
    parameter int                PC_W     = 8,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [INST_W-1:0] d_inst,
    output logic              q_valid,
    output logic [PC_W-1:0]   q_pc,
    output logic [INST_W-1:0] q_inst
);

    logic              valid_r;
    logic [PC_W-1:0]   pc_r;
    logic [INST_W-1:0] inst_r;

    // Slot storage: async reset, clear has priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= {PC_W{1'b0}};
            inst_r  <= NOP_INST;
        end else if (clear) begin
            valid_r <= 1'b0;
            pc_r    <= {PC_W{1'b0}};
            inst_r  <= NOP_INST;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= d_pc;
            inst_r  <= d_inst;
        end else begin
            valid_r <= valid_r;
            pc_r    <= pc_r;
            inst_r  <= inst_r;
        end
    end

    assign q_valid = valid_r;
    assign q_pc    = pc_r;
    assign q_inst  = inst_r;

endmodule

// File: rtl/ifid_pipe.sv
// IF/ID pipeline register with a one-entry skid buffer, load-use hold,
// bubble insertion and flush. Head slot drives decode; skid catches overflow.
module ifid_pipe
    import ifid_pipe_pkg::*;
#(
    parameter int                PC_W     = 8,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [1:0]        occ
);

    occ_e              state_r;
    occ_e              state_nxt_s;
    logic              in_ready_r;
    logic              accept_s;
    logic              pop_s;
    logic              head_load_s;
    logic              head_clear_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic [PC_W-1:0]   head_d_pc_s;
    logic [INST_W-1:0] head_d_inst_s;
    logic              skid_valid_s;
    logic [PC_W-1:0]   skid_pc_s;
    logic [INST_W-1:0] skid_inst_s;

    assign in_ready = in_ready_r & ~flush & ~bubble;
    assign accept_s = in_valid & in_ready;
    assign pop_s    = out_valid & out_ready;

    // Slot controls and occupancy next state; flush beats bubble beats normal flow.
    always_comb begin
        head_load_s   = 1'b0;
        head_clear_s  = 1'b0;
        skid_load_s   = 1'b0;
        skid_clear_s  = 1'b0;
        head_d_pc_s   = in_pc;
        head_d_inst_s = in_inst;
        state_nxt_s   = state_r;
        if (flush) begin
            head_clear_s = 1'b1;
            skid_clear_s = 1'b1;
            state_nxt_s  = OCC_EMPTY;
        end else if (bubble) begin
            // The NOP keeps the head's pc; a held head is left untouched.
            if (pop_s || !out_valid) begin
                head_load_s   = 1'b1;
                head_d_pc_s   = out_pc;
                head_d_inst_s = NOP_INST;
            end else begin
                head_load_s = 1'b0;
            end
            if (state_r == OCC_EMPTY) begin
                state_nxt_s = OCC_ONE;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            if (pop_s && skid_valid_s) begin
                head_load_s   = 1'b1;
                head_d_pc_s   = skid_pc_s;
                head_d_inst_s = skid_inst_s;
                skid_clear_s  = 1'b1;
            end else if (accept_s && (pop_s || !out_valid)) begin
                head_load_s = 1'b1;
            end else if (accept_s) begin
                skid_load_s = 1'b1;
            end else if (pop_s) begin
                head_clear_s = 1'b1;
            end else begin
                head_load_s = 1'b0;
            end
            case (state_r)
                OCC_EMPTY: state_nxt_s = accept_s ? OCC_ONE : OCC_EMPTY;
                OCC_ONE: begin
                    if (accept_s && !pop_s) begin
                        state_nxt_s = OCC_TWO;
                    end else if (pop_s && !accept_s) begin
                        state_nxt_s = OCC_EMPTY;
                    end else begin
                        state_nxt_s = OCC_ONE;
                    end
                end
                OCC_TWO:   state_nxt_s = pop_s ? OCC_ONE : OCC_TWO;
                default:   state_nxt_s = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy state and registered ready (ready means skid will be empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= OCC_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != OCC_TWO);
        end
    end

    ifid_entry #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_head (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (head_clear_s),
        .load    (head_load_s),
        .d_pc    (head_d_pc_s),
        .d_inst  (head_d_inst_s),
        .q_valid (out_valid),
        .q_pc    (out_pc),
        .q_inst  (out_inst)
    );

    ifid_entry #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (skid_clear_s),
        .load    (skid_load_s),
        .d_pc    (in_pc),
        .d_inst  (in_inst),
        .q_valid (skid_valid_s),
        .q_pc    (skid_pc_s),
        .q_inst  (skid_inst_s)
    );

    assign out_rs = out_inst[RS_HI:RS_LO];
    assign out_rt = out_inst[RT_HI:RT_LO];
    assign occ    = state_r;

endmodule

// File: tb/tb_ifid_pipe.sv
// Bench for ifid_pipe: directed vector table, async reset sequence, then
// random traffic checked against a queue-based reference model.
module tb_ifid_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        bubble;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [1:0]  occ;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        iv;
        logic [7:0]  pc;
        logic [31:0] inst;
        logic        fl;
        logic        bu;
        logic        ordy;
        logic        e_ir;
        logic        e_v;
        logic [7:0]  e_pc;
        logic [31:0] e_inst;
        logic [1:0]  e_occ;
    } vec_t;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] inst;
    } ent_t;

    vec_t vecs[19];
    ent_t mq[$];

    ifid_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .bubble    (bubble),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string pfx, input logic e_v, input logic [7:0] e_pc,
                             input logic [31:0] e_inst, input logic [1:0] e_occ);
        logic [31:0] ei;
        ei = e_inst;
        check({pfx, ".valid"}, 64'(out_valid), 64'(e_v));
        check({pfx, ".pc"},    64'(out_pc),    64'(e_pc));
        check({pfx, ".inst"},  64'(out_inst),  64'(ei));
        check({pfx, ".rs"},    64'(out_rs),    64'(ei[25:21]));
        check({pfx, ".rt"},    64'(out_rt),    64'(ei[20:16]));
        check({pfx, ".occ"},   64'(occ),       64'(e_occ));
    endtask

    task automatic drive(input logic iv, input logic [7:0] pc, input logic [31:0] inst,
                         input logic fl, input logic bu, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        flush     = fl;
        bubble    = bu;
        out_ready = ordy;
    endtask

    // One model cycle: predict ready, clock, apply FIFO rules, compare outputs.
    task automatic model_step(input logic iv, input logic [7:0] pc, input logic [31:0] inst,
                              input logic fl, input logic bu, input logic ordy);
        logic m_ir;
        logic acc;
        logic pop;
        ent_t e;
        drive(iv, pc, inst, fl, bu, ordy);
        #1;
        m_ir = (mq.size() < 2) && !fl && !bu;
        check("rnd.in_ready", 64'(in_ready), 64'(m_ir));
        acc = iv && m_ir;
        pop = (mq.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else if (bu) begin
            if (mq.size() == 0) begin
                e.pc = 8'h00;
                e.inst = 32'h0;
                mq.push_back(e);
            end else if (pop) begin
                e = mq[0];
                e.inst = 32'h0;
                mq[0] = e;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.pc = pc;
                e.inst = inst;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) begin
            e = mq[0];
            check_out("rnd", 1'b1, e.pc, e.inst, 2'(mq.size()));
        end else begin
            check_out("rnd", 1'b0, 8'h00, 32'h0, 2'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);

        //          iv    pc     inst          fl    bu    ordy  e_ir  e_v   e_pc   e_inst        e_occ
        vecs[0]  = '{1'b1, 8'h04, 32'h8C220004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 32'h8C220004, 2'd1};
        vecs[1]  = '{1'b1, 8'h08, 32'h11110008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 32'h8C220004, 2'd2};
        vecs[2]  = '{1'b1, 8'h0C, 32'h2222000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 32'h8C220004, 2'd2};
        vecs[3]  = '{1'b1, 8'h0C, 32'h2222000C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 32'h11110008, 2'd1};
        vecs[4]  = '{1'b1, 8'h0C, 32'h2222000C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0C, 32'h2222000C, 2'd1};
        vecs[5]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00000000, 2'd0};
        vecs[6]  = '{1'b1, 8'h20, 32'h33330020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 32'h33330020, 2'd1};
        vecs[7]  = '{1'b1, 8'h24, 32'h44440024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 32'h33330020, 2'd2};
        vecs[8]  = '{1'b1, 8'h28, 32'h55550028, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 2'd0};
        vecs[9]  = '{1'b1, 8'h10, 32'h66660010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 32'h66660010, 2'd1};
        vecs[10] = '{1'b1, 8'h14, 32'h77770014, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 32'h00000000, 2'd1};
        vecs[11] = '{1'b1, 8'h14, 32'h77770014, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 32'h77770014, 2'd1};
        vecs[12] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 32'h77770014, 2'd1};
        vecs[13] = '{1'b1, 8'h18, 32'h88880018, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h14, 32'h77770014, 2'd2};
        vecs[14] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 32'h00000000, 2'd2};
        vecs[15] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h18, 32'h88880018, 2'd1};
        vecs[16] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00000000, 2'd0};
        vecs[17] = '{1'b1, 8'h30, 32'h99990030, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h00000000, 2'd1};
        vecs[18] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h00000000, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 32'h0, 2'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].fl, vecs[i].bu, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_occ);
        end

        // Asynchronous reset in the middle of a cycle while both slots are full.
        drive(1'b1, 8'h50, 32'hAAAA0050, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 8'h54, 32'hBBBB0054, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("pre_rst", 1'b1, 8'h50, 32'hAAAA0050, 2'd2);
        drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 32'h0, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 8'h40, 32'hCCCC0040, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_out("post_rst", 1'b1, 8'h40, 32'hCCCC0040, 2'd1);

        // Drain, then random traffic against the queue model.
        drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_out("drain", 1'b0, 8'h00, 32'h0, 2'd0);
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            model_step(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom),
                       1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_pipe.md
IFID_PIPE -- requirements
Module: ifid_pipe

Interface
REQ-001 Parameter PC_W, 8, fetch address width.
REQ-002 Parameter INST_W, 32, instruction width (SHALL be >= 26).
REQ-003 Parameter NOP_INST, 0, encoding loaded on bubble/flush.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  fetch stage presents pc/inst.
REQ-007 in_ready  out  1  stage accepts input this cycle.
REQ-008 in_pc  in  PC_W  fetch address.
REQ-009 in_inst  in  INST_W  fetched instruction.
REQ-010 flush  in  1  discard all held and incoming entries.
REQ-011 bubble  in  1  insert one NOP toward decode.
REQ-012 out_ready  in  1  decode consumes head entry (0 = load-use hold).
REQ-013 out_valid  out  1  head entry valid.
REQ-014 out_pc  out  PC_W  head address.
REQ-015 out_inst  out  INST_W  head instruction.
REQ-016 out_rs  out  5  out_inst[25:21].
REQ-017 out_rt  out  5  out_inst[20:16].
REQ-018 occ  out  2  entries held (0..2).

Function
REQ-019 Storage SHALL be two entries: head (drives outputs) and skid; occupancy states EMPTY, ONE, TWO.
REQ-020 in_ready SHALL be a registered signal, 1 iff skid empty, and SHALL be 0 in any cycle flush or bubble is high (combinational gating).
REQ-021 Accept = in_valid & in_ready; pop = out_valid & out_ready; all outputs registered, latency in->out 1 cycle when EMPTY.
REQ-022 Transitions: EMPTY+accept -> ONE; ONE+accept&~pop -> TWO; ONE+pop&~accept -> EMPTY; ONE+accept&pop -> ONE (head = new data); TWO+pop -> ONE (skid moves to head); TWO never accepts.
REQ-023 Entry order SHALL be strictly FIFO; no entry duplicated or dropped except by flush.
REQ-024 flush SHALL take priority over all: next state EMPTY, out_valid 0, out_inst NOP_INST, out_pc 0, input not accepted.
REQ-025 bubble (no flush) SHALL: if pop or EMPTY, load head with {pc unchanged, NOP_INST, valid 1}, skid preserved, no accept; if head held (~pop), no state change.
REQ-026 bubble in TWO with pop: skid entry SHALL remain in skid and head becomes NOP; occ stays 2.
REQ-027 When out_valid 0, out_inst SHALL equal NOP_INST.
REQ-028 out_rs/out_rt SHALL be combinational slices of out_inst.
REQ-029 occ SHALL equal number of valid entries, counting a bubble NOP as an entry.

Reset
REQ-030 rst_n low SHALL asynchronously clear both entries: occ 0, out_valid 0, out_pc 0, out_inst NOP_INST, in_ready 1 after release.
REQ-031 Reset mid-operation SHALL discard held entries with no partial state; first accept after release behaves as from EMPTY.

Structure
REQ-032 Shared package SHALL hold occupancy state encodings and the rs/rt field bit positions; PC_W/INST_W/NOP_INST stay module parameters.
REQ-033 One sub-module natural: ifid_entry (one registered pc/inst/valid slot with load/clear controls), instantiated twice.

Verification
REQ-034 Reset, then in_valid=1 pc=0x04 inst=0x8C220004, out_ready=1 -> next cycle out_valid=1, out_pc=0x04, out_rs=1, out_rt=2, occ=1.
REQ-035 out_ready=0 while feeding pc 0x04,0x08,0x0C -> occ 2, in_ready 0 after second accept; 0x0C held upstream; release -> outputs 0x04,0x08,0x0C in order.
REQ-036 occ=2, flush=1 with in_valid=1 -> next cycle occ 0, out_valid 0, out_inst 0, input not taken.
REQ-037 occ=1 head pc 0x10, bubble=1 with out_ready=1 -> head inst 0, valid 1, pc 0x10, in_ready 0 that cycle; next input appears one cycle later.
REQ-038 rst_n low asynchronously mid-cycle with occ=2 -> outputs cleared before next clock edge; occ 0.
REQ-039 Random in_valid/out_ready/bubble, 10k cycles, scoreboard -> FIFO order, no loss, occ consistent.
